// File: rtl/markov_pred_ctrl.sv
// Markov bit predictor: a 2^HIST_W-entry table of 2-bit saturating counters,
// indexed by the most recent HIST_W bits, predicts each bit of an input word
// (MSB first). It reports the per-bit predictions, the mispredict count of
// the word, and a saturating cumulative mispredict count.
module markov_pred_ctrl #(
  parameter int HIST_W = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_pred,
  output logic [3:0]        out_miss,
  output logic [HIST_W-1:0] lane,
  output logic              bit_out,
  output logic [CNT_W-1:0]  miss_total
);

  localparam int unsigned LANES = 1 << HIST_W;
  localparam int          IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_OUT
  } state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   data_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-1:0]   pred_q;
  logic [3:0]          miss_q;
  logic [HIST_W-1:0]   hist_q;
  logic [CNT_W-1:0]    total_q;
  logic                valid_q;
  logic [1:0]          cnt_q [LANES];

  logic                cur_bit;
  logic                mispred;
  logic [1:0]          cnt_d;
  logic [HIST_W-1:0]   hist_d;
  logic [CNT_W-1:0]    total_d;

  assign bit_out    = cnt_q[hist_q][1];
  assign lane       = hist_q;
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = valid_q;
  assign out_pred   = pred_q;
  assign out_miss   = miss_q;
  assign miss_total = total_q;

  // Next values for the active lane's counter, history and the miss total
  always_comb begin
    cur_bit = data_q[WORD_W-1];
    mispred = (cur_bit != bit_out);
    cnt_d   = cnt_q[hist_q];
    if (cur_bit) begin
      if (cnt_q[hist_q] != 2'b11) cnt_d = cnt_q[hist_q] + 2'b01;
    end else begin
      if (cnt_q[hist_q] != 2'b00) cnt_d = cnt_q[hist_q] - 2'b01;
    end
    hist_d  = {hist_q[HIST_W-2:0], cur_bit};
    total_d = total_q;
    if (mispred && (total_q != '1)) total_d = total_q + CNT_W'(1);
  end

  // Control FSM with predictor state and registered outputs; clear overrides all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      pred_q  <= '0;
      miss_q  <= '0;
      hist_q  <= '0;
      total_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '{default: 2'b01};
    end else if (clear) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      hist_q  <= '0;
      total_q <= '0;
      cnt_q   <= '{default: 2'b01};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            pred_q  <= '0;
            miss_q  <= '0;
            idx_q   <= IDX_W'(WORD_W - 1);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Data and prediction both shift left, so the current bit is always
          // the data MSB and predictions land MSB-first in out_pred.
          pred_q         <= {pred_q[WORD_W-2:0], bit_out};
          data_q         <= data_q << 1;
          if (mispred) miss_q <= miss_q + 4'd1;
          total_q        <= total_d;
          cnt_q[hist_q]  <= cnt_d;
          hist_q         <= hist_d;
          idx_q          <= idx_q - IDX_W'(1);
          if (idx_q == '0) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/markov_pred_ctrl.md
MARKOV_PRED_CTRL -- requirements
Module: markov_pred_ctrl

Interface
REQ-001 SHALL provide parameter HIST_W, default 4: history length in bits; lanes = 2^HIST_W (16).
REQ-002 SHALL provide parameter WORD_W, default 8: input word width in bits.
REQ-003 SHALL provide parameter CNT_W, default 16: width of the cumulative miss counter.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: input word offered.
REQ-007 SHALL have port in_ready, output, 1: block can accept a word.
REQ-008 SHALL have port in_data, input, WORD_W: word to be predicted bit-serially, MSB first.
REQ-009 SHALL have port clear, input, 1: synchronous clear of predictor state and abort of any word in flight.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port out_pred, output, WORD_W: predicted bit for each input bit position.
REQ-013 SHALL have port out_miss, output, 4: mispredicted bits in the word, 0..WORD_W.
REQ-014 SHALL have port lane, output, HIST_W: current history register, i.e. active lane.
REQ-015 SHALL have port bit_out, output, 1: current prediction, MSB of the lane's counter; combinational from lane.
REQ-016 SHALL have port miss_total, output, CNT_W: cumulative mispredict count.

Function
REQ-017 SHALL keep 2^HIST_W 2-bit saturating counters; prediction = counter[1].
REQ-018 SHALL implement FSM IDLE -> SHIFT -> OUT -> IDLE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch in_data, clear the word miss count and out_pred, set bit index WORD_W-1, go to SHIFT.
REQ-020 SHIFT: in_ready=0; one bit per cycle, MSB first; per bit b: out_pred[idx]<=bit_out; if b!=bit_out, increment the word miss count and miss_total.
REQ-021 SHIFT counter update, lane=hist: b=1 -> counter+1 saturating at 3; b=0 -> counter-1 saturating at 0; then hist <= {hist[HIST_W-2:0], b}.
REQ-022 After the WORD_W-th bit, SHALL go to OUT; out_valid SHALL rise exactly WORD_W edges after the accepting edge.
REQ-023 OUT: out_valid=1; out_pred and out_miss held stable; in_ready=0; on out_ready=1, go to IDLE and drop out_valid at that edge.
REQ-024 miss_total SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 clear=1 at an edge, any state, SHALL take priority over all other events: counters<=2'b01, hist<=0, miss_total<=0, out_valid<=0, state<=IDLE; any partial word is discarded with no output.
REQ-026 in_valid while not in IDLE SHALL be ignored; the word is not consumed.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, all counters=2'b01, hist=0, miss_total=0, out_pred=0, out_miss=0, out_valid=0, in_ready=1 after release, bit_out=0, lane=0.
REQ-028 Reset asserted mid-SHIFT or mid-OUT SHALL discard the word and drop out_valid without a clock edge.

Verification
REQ-029 After reset, send word 0x00 -> out_pred=0x00, out_miss=0, miss_total=0, lane=0x0.
REQ-030 After reset, send word 0xFF -> out_valid 8 edges after accept; out_pred=0x07, out_miss=5, miss_total=5, lane=0xF.
REQ-031 Immediately send a second 0xFF -> out_pred=0xFF, out_miss=0, miss_total=5.
REQ-032 Hold out_ready=0 for 5 cycles in OUT -> out_valid, out_pred and out_miss stable and in_ready=0 throughout; the next word is accepted only after the out_ready handshake.
REQ-033 Assert clear on the 3rd SHIFT cycle -> next cycle in IDLE, in_ready=1, no out_valid pulse, lane=0, miss_total=0.
REQ-034 Drop reset asynchronously while out_valid=1 -> out_valid=0 before the next clock edge; after release, block is in IDLE.
